// File: rtl/stream_comp_pkg.sv
// Shared constants for the CFDF stream-compute actor: modes, opcodes, FSM states.
package stream_comp_pkg;

  localparam logic [1:0] MODE_CMD  = 2'd0;
  localparam logic [1:0] MODE_DATA = 2'd1;
  localparam logic [1:0] MODE_OUT  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam logic [1:0] OP_SUM = 2'd0;
  localparam logic [1:0] OP_MAX = 2'd1;
  localparam logic [1:0] OP_MIN = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CMD_RD     = 3'd1,
    ST_CMD_LATCH  = 3'd2,
    ST_DATA_RD    = 3'd3,
    ST_DATA_DRAIN = 3'd4,
    ST_OUT_WR     = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  // Ceiling log2, used to size population and capacity ports.
  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_comp_alu.sv
// Single-step reduce of one token into the accumulator.
// STREAM_COMP_SAT_EN: when defined, SUM saturates instead of wrapping.
module stream_comp_alu
  import stream_comp_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_tok,
  input  logic [WIDTH-1:0] i_op,
  output logic [WIDTH-1:0] o_acc_next,
  output logic             o_illegal
);

  logic             w_op_legal;
  logic [WIDTH-1:0] w_sum;

  assign w_op_legal = (i_op[WIDTH-1:2] == '0);

`ifdef STREAM_COMP_SAT_EN
  logic [WIDTH:0] w_sum_ext;
  assign w_sum_ext = {1'b0, i_acc} + {1'b0, i_tok};
  assign w_sum     = w_sum_ext[WIDTH] ? '1 : w_sum_ext[WIDTH-1:0];
`else
  assign w_sum = i_acc + i_tok;
`endif

  always_comb begin
    o_acc_next = '0;
    o_illegal  = 1'b0;
    if (!w_op_legal) begin
      // Illegal opcodes still consume data but pin the result at zero.
      o_illegal  = 1'b1;
      o_acc_next = '0;
    end else begin
      case (i_op[1:0])
        OP_SUM:  o_acc_next = w_sum;
        OP_MAX:  o_acc_next = (i_tok > i_acc) ? i_tok : i_acc;
        OP_MIN:  o_acc_next = (i_tok < i_acc) ? i_tok : i_acc;
        default: o_acc_next = i_acc ^ i_tok;
      endcase
    end
  end

endmodule

// File: rtl/stream_comp_cfdf_actor.sv
// CFDF stream-compute actor: CMD/DATA/OUT firings with enable logic.
// Optional STREAM_COMP_SAT_EN selects saturating SUM inside stream_comp_alu.
//
// state         | meaning
// ST_IDLE       | waiting for invoke with enable
// ST_CMD_RD     | rd_cmd/rd_len strobed
// ST_CMD_LATCH  | opcode/length latched, accumulator initialised
// ST_DATA_RD    | rd_data strobed once per cycle, length_out cycles
// ST_DATA_DRAIN | last token absorbed
// ST_OUT_WR     | wr_result strobed with accumulator
// ST_DONE       | fc pulse, next_mode_out valid
module stream_comp_cfdf_actor
  import stream_comp_pkg::*;
#(
  parameter  int WIDTH           = 10,
  parameter  int BUFFER_SIZE     = 10,
  parameter  int BUFFER_SIZE_OUT = 1,
  localparam int POP_W           = log2(BUFFER_SIZE),
  localparam int CAP_W           = (log2(BUFFER_SIZE_OUT) < 1) ? 1 : log2(BUFFER_SIZE_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             invoke,
  input  logic [1:0]       next_mode_in,
  input  logic [POP_W-1:0] pop_cmd,
  input  logic [POP_W-1:0] pop_len,
  input  logic [POP_W-1:0] pop_data,
  input  logic [CAP_W-1:0] cap_result,
  input  logic [WIDTH-1:0] cmd_in,
  input  logic [WIDTH-1:0] len_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             enable,
  output logic             rd_cmd,
  output logic             rd_len,
  output logic             rd_data,
  output logic             wr_result,
  output logic [WIDTH-1:0] result_out,
  output logic [1:0]       next_mode_out,
  output logic [WIDTH-1:0] length_out,
  output logic             fc,
  output logic             err
);

  state_t           r_state;
  logic             r_rd_cmd;
  logic             r_rd_len;
  logic             r_rd_data;
  logic             r_wr_result;
  logic             r_fc;
  logic             r_err;
  logic             r_tok_vld;
  logic [1:0]       r_next_mode;
  logic [WIDTH-1:0] r_length;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opcode;
  logic [WIDTH-1:0] r_cnt;

  logic [WIDTH-1:0] w_alu_op;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_illegal;

  always_comb begin
    enable = 1'b0;
    case (next_mode_in)
      MODE_CMD:  enable = (pop_cmd >= POP_W'(1)) && (pop_len >= POP_W'(1));
      MODE_DATA: enable = (WIDTH'(pop_data) >= r_length);
      MODE_OUT:  enable = (cap_result >= CAP_W'(1));
      default:   enable = 1'b0;
    endcase
  end

  // The ALU decodes the incoming command while latching so err is known at once.
  assign w_alu_op = (r_state == ST_CMD_LATCH) ? cmd_in : r_opcode;

  stream_comp_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_acc     (r_acc),
    .i_tok     (data_in),
    .i_op      (w_alu_op),
    .o_acc_next(w_acc_next),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rd_cmd    <= 1'b0;
      r_rd_len    <= 1'b0;
      r_rd_data   <= 1'b0;
      r_wr_result <= 1'b0;
      r_fc        <= 1'b0;
      r_err       <= 1'b0;
      r_tok_vld   <= 1'b0;
      r_next_mode <= MODE_CMD;
      r_length    <= '0;
      r_result    <= '0;
      r_acc       <= '0;
      r_opcode    <= '0;
      r_cnt       <= '0;
    end else begin
      // Read data arrives one cycle after its strobe.
      r_tok_vld <= r_rd_data;
      if (r_tok_vld) r_acc <= w_acc_next;

      case (r_state)
        ST_IDLE: begin
          if (invoke && enable) begin
            case (next_mode_in)
              MODE_CMD: begin
                r_rd_cmd <= 1'b1;
                r_rd_len <= 1'b1;
                r_state  <= ST_CMD_RD;
              end
              MODE_DATA: begin
                r_cnt <= r_length;
                if (r_length != '0) begin
                  r_rd_data <= 1'b1;
                  r_state   <= ST_DATA_RD;
                end else begin
                  r_state <= ST_DATA_DRAIN;
                end
              end
              MODE_OUT: begin
                r_wr_result <= 1'b1;
                r_result    <= r_acc;
                r_state     <= ST_OUT_WR;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_CMD_RD: begin
          r_rd_cmd <= 1'b0;
          r_rd_len <= 1'b0;
          r_state  <= ST_CMD_LATCH;
        end
        ST_CMD_LATCH: begin
          r_opcode    <= cmd_in;
          r_length    <= len_in;
          r_acc       <= (cmd_in == WIDTH'(OP_MIN)) ? '1 : '0;
          r_err       <= w_illegal;
          r_next_mode <= (len_in == '0) ? MODE_OUT : MODE_DATA;
          r_fc        <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DATA_RD: begin
          if (r_cnt == WIDTH'(1)) begin
            r_rd_data <= 1'b0;
            r_state   <= ST_DATA_DRAIN;
          end else begin
            r_cnt <= r_cnt - WIDTH'(1);
          end
        end
        ST_DATA_DRAIN: begin
          r_next_mode <= MODE_OUT;
          r_fc        <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_OUT_WR: begin
          r_wr_result <= 1'b0;
          r_next_mode <= MODE_CMD;
          r_fc        <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          r_fc    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_cmd        = r_rd_cmd;
  assign rd_len        = r_rd_len;
  assign rd_data       = r_rd_data;
  assign wr_result     = r_wr_result;
  assign result_out    = r_result;
  assign next_mode_out = r_next_mode;
  assign length_out    = r_length;
  assign fc            = r_fc;
  assign err           = r_err;

endmodule

// File: tb/tb_stream_comp_cfdf_actor.sv
// Directed bench for stream_comp_cfdf_actor: firings, gating, opcodes, reset abort.
module tb_stream_comp_cfdf_actor;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         invoke = 1'b0;
  logic [1:0]   next_mode_in = 2'd0;
  logic [3:0]   pop_cmd = '0, pop_len = '0, pop_data = '0;
  logic [0:0]   cap_result = '0;
  logic [W-1:0] cmd_in = '0, len_in = '0, data_in = '0;
  logic         enable, rd_cmd, rd_len, rd_data, wr_result, fc, err;
  logic [W-1:0] result_out, length_out;
  logic [1:0]   next_mode_out;

  stream_comp_cfdf_actor dut (
    .clk(clk), .rst(rst), .invoke(invoke), .next_mode_in(next_mode_in),
    .pop_cmd(pop_cmd), .pop_len(pop_len), .pop_data(pop_data), .cap_result(cap_result),
    .cmd_in(cmd_in), .len_in(len_in), .data_in(data_in),
    .enable(enable), .rd_cmd(rd_cmd), .rd_len(rd_len), .rd_data(rd_data),
    .wr_result(wr_result), .result_out(result_out), .next_mode_out(next_mode_out),
    .length_out(length_out), .fc(fc), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic [W-1:0] tok [8];
  logic [W-1:0] cmd_v, len_v, wr_val;
  logic         en_at_inv;
  int rdcmd_cyc, rdlen_n, rd_n, rd_first, rd_last, wr_cyc, wr_n, fc_cyc, blk_n;

  // One firing: invoke in cycle 0, then record strobes per cycle until fc.
  task automatic fire(input logic [1:0] mode);
    int ti;
    logic s_rd, s_cmd;
    ti = 0;
    rdcmd_cyc = 0; rdlen_n = 0; rd_n = 0; rd_first = 0; rd_last = 0;
    wr_cyc = 0; wr_n = 0; fc_cyc = 0; wr_val = '0;
    @(negedge clk);
    next_mode_in = mode;
    en_at_inv = enable;
    invoke = 1'b1;
    @(posedge clk);
    #1 invoke = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      s_rd  = rd_data;
      s_cmd = rd_cmd;
      if (rd_cmd && rdcmd_cyc == 0) rdcmd_cyc = c;
      if (rd_len) rdlen_n++;
      if (rd_data) begin
        rd_n++;
        if (rd_first == 0) rd_first = c;
        rd_last = c;
      end
      if (wr_result) begin
        wr_n++;
        wr_cyc = c;
        wr_val = result_out;
      end
      if (fc) begin
        fc_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
      if (s_rd && ti < 8) begin
        data_in = tok[ti];
        ti++;
      end
      if (s_cmd) begin
        cmd_in = cmd_v;
        len_in = len_v;
      end
    end
  endtask

  // Invoke held for several cycles while the firing should be blocked.
  task automatic try_blocked(input logic [1:0] mode);
    blk_n = 0;
    @(negedge clk);
    next_mode_in = mode;
    invoke = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rd_cmd || rd_len || rd_data || wr_result || fc) blk_n++;
    end
    invoke = 1'b0;
  endtask

  task automatic do_cmd(input logic [W-1:0] c, input logic [W-1:0] l);
    cmd_v = c;
    len_v = l;
    fire(2'd0);
  endtask

  logic [W-1:0] sat_exp;
  int n_pre;

  initial begin
    pop_cmd = 4'd1;
    pop_len = 4'd1;
    repeat (3) @(negedge clk);
    chk_val("rst_strobes", {rd_cmd, rd_len, rd_data, wr_result}, 4'b0000);
    chk_val("rst_fc_err", {fc, err}, 2'b00);
    chk_val("rst_result", result_out, 0);
    chk_val("rst_length", length_out, 0);
    chk_val("rst_mode", next_mode_out, 0);
    @(negedge clk);
    rst = 1'b1;

    // CMD: SUM, length 5
    do_cmd(10'd0, 10'd5);
    chk_val("cmd_enable", en_at_inv, 1);
    chk_val("cmd_rd_cyc", rdcmd_cyc, 1);
    chk_val("cmd_rdlen_n", rdlen_n, 1);
    chk_val("cmd_fc_cyc", fc_cyc, 3);
    chk_val("cmd_mode", next_mode_out, 1);
    chk_val("cmd_length", length_out, 5);
    chk_val("cmd_err", err, 0);

    // DATA gated: only 3 tokens for length 5
    pop_data = 4'd3;
    next_mode_in = 2'd1;
    #1 chk_val("gate_data_en", enable, 0);
    try_blocked(2'd1);
    chk_val("gate_data_strobes", blk_n, 0);
    chk_val("gate_data_mode", next_mode_out, 1);

    // DATA: 1..5
    pop_data = 4'd5;
    tok[0] = 10'd1; tok[1] = 10'd2; tok[2] = 10'd3; tok[3] = 10'd4; tok[4] = 10'd5;
    fire(2'd1);
    chk_val("data_enable", en_at_inv, 1);
    chk_val("data_rd_n", rd_n, 5);
    chk_val("data_rd_first", rd_first, 1);
    chk_val("data_rd_last", rd_last, 5);
    chk_val("data_fc_cyc", fc_cyc, 7);
    chk_val("data_mode", next_mode_out, 2);

    // OUT gated by full result FIFO, then written
    cap_result = 1'b0;
    next_mode_in = 2'd2;
    #1 chk_val("gate_out_en", enable, 0);
    cap_result = 1'b1;
    fire(2'd2);
    chk_val("out_wr_cyc", wr_cyc, 1);
    chk_val("out_wr_n", wr_n, 1);
    chk_val("out_sum15", wr_val, 15);
    chk_val("out_fc_cyc", fc_cyc, 2);
    chk_val("out_mode", next_mode_out, 0);

    // Reserved mode never enables
    next_mode_in = 2'd3;
    #1 chk_val("rsvd_en", enable, 0);

    // SUM overflow: 1000 + 100
`ifdef STREAM_COMP_SAT_EN
    sat_exp = 10'd1023;
`else
    sat_exp = 10'd76;
`endif
    do_cmd(10'd0, 10'd2);
    pop_data = 4'd2;
    tok[0] = 10'd1000; tok[1] = 10'd100;
    fire(2'd1);
    fire(2'd2);
    chk_val("sum_ovf", wr_val, sat_exp);

    // MAX of 7, 300, 12
    do_cmd(10'd1, 10'd3);
    pop_data = 4'd3;
    tok[0] = 10'd7; tok[1] = 10'd300; tok[2] = 10'd12;
    fire(2'd1);
    fire(2'd2);
    chk_val("max_val", wr_val, 300);

    // MIN with zero length goes straight to OUT
    do_cmd(10'd2, 10'd0);
    chk_val("min0_mode", next_mode_out, 2);
    chk_val("min0_length", length_out, 0);
    fire(2'd2);
    chk_val("min0_result", wr_val, 1023);

    // Illegal opcode 7, length 2
    do_cmd(10'd7, 10'd2);
    chk_val("ill_err", err, 1);
    chk_val("ill_mode", next_mode_out, 1);
    tok[0] = 10'd9; tok[1] = 10'd9;
    fire(2'd1);
    chk_val("ill_rd_n", rd_n, 2);
    fire(2'd2);
    chk_val("ill_result", wr_val, 0);

    // XOR of 5, 3 also clears err
    do_cmd(10'd3, 10'd2);
    chk_val("xor_err_clr", err, 0);
    tok[0] = 10'd5; tok[1] = 10'd3;
    fire(2'd1);
    fire(2'd2);
    chk_val("xor_val", wr_val, 6);

    // Reset during DATA_RD after 2 of 5 reads
    do_cmd(10'd0, 10'd5);
    pop_data = 4'd5;
    @(negedge clk);
    next_mode_in = 2'd1;
    invoke = 1'b1;
    @(posedge clk);
    #1 invoke = 1'b0;
    n_pre = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rd_data) n_pre++;
      if (n_pre == 2) break;
    end
    chk_val("abort_reads", n_pre, 2);
    rst = 1'b0;
    #1;
    chk_val("abort_strobes", {rd_cmd, rd_len, rd_data, wr_result}, 4'b0000);
    chk_val("abort_mode", next_mode_out, 0);
    chk_val("abort_length", length_out, 0);
    chk_val("abort_out", {fc, err, result_out}, 0);
    @(negedge clk);
    rst = 1'b1;
    do_cmd(10'd0, 10'd1);
    chk_val("post_abort_fc", fc_cyc, 3);
    chk_val("post_abort_len", length_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_comp_cfdf_actor.md
# stream_comp_cfdf_actor

Parametrised CFDF stream-compute actor with integrated enable logic. Consumes one command token and one length token, then `length` data tokens from external FIFOs, and reduces them with the commanded operation. It writes one result token to the result FIFO. It sits between the command/length/data input FIFOs and the result FIFO, and is driven by a scheduler through `invoke`/`next_mode_in`/`fc`.

## Interface
Parameters:
- `WIDTH`, 10: width of the command, length, data and result tokens.
- `BUFFER_SIZE`, 10: depth of the input FIFOs; `POP_W = log2(BUFFER_SIZE)`.
- `BUFFER_SIZE_OUT`, 1: depth of the result FIFO; `CAP_W = log2(BUFFER_SIZE_OUT)`, minimum 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `invoke` in 1: fire the mode given by `next_mode_in`.
- `next_mode_in` in 2: mode to fire. 0 = CMD, 1 = DATA, 2 = OUT, 3 = reserved.
- `pop_cmd`, `pop_len`, `pop_data` in POP_W: populations of the input FIFOs.
- `cap_result` in CAP_W: free slots in the result FIFO.
- `cmd_in`, `len_in`, `data_in` in WIDTH: FIFO read data, valid the cycle after the matching `rd_*`.
- `enable` out 1: combinational; the firing of `next_mode_in` is possible.
- `rd_cmd`, `rd_len`, `rd_data` out 1: FIFO read strobes.
- `wr_result` out 1: result FIFO write strobe.
- `result_out` out WIDTH: result token.
- `next_mode_out` out 2: mode the actor requires next.
- `length_out` out WIDTH: latched length.
- `fc` out 1: firing-complete pulse.
- `err` out 1: the last CMD firing decoded an illegal opcode.

## Operation
Enable rules:
- CMD mode: `enable` = `pop_cmd >= 1 && pop_len >= 1`.
- DATA mode: `enable` = `pop_data >= length_out`.
- OUT mode: `enable` = `cap_result >= 1`.
- Reserved mode: `enable` = 0.

State machine:
- States: IDLE, CMD_RD, CMD_LATCH, DATA_RD, DATA_DRAIN, OUT_WR, DONE.
- `invoke` is sampled only in IDLE with `enable` = 1. It is ignored otherwise, with no state change.

CMD firing:
- IDLE → CMD_RD: `rd_cmd` = `rd_len` = 1 for one cycle.
- CMD_LATCH: latch opcode and length, and initialise the accumulator.
- `next_mode_out` becomes DATA, or OUT if length = 0.

DATA firing:
- DATA_RD asserts `rd_data` for exactly `length_out` consecutive cycles.
- Each token is accumulated the cycle after its strobe.
- DATA_DRAIN absorbs the final token.
- `next_mode_out` becomes OUT.

OUT firing:
- OUT_WR asserts `wr_result` for one cycle with `result_out` = accumulator.
- `next_mode_out` becomes CMD.

Every firing ends in DONE: `fc` = 1 for one cycle, `next_mode_out` updates, then return to IDLE.

Opcodes (unsigned arithmetic):

| Opcode | Operation | Accumulator init |
|---|---|---|
| 0 | SUM | 0 |
| 1 | MAX | 0 |
| 2 | MIN | all-ones |
| 3 | XOR | 0 |

- Any other opcode sets `err` = 1. Data is still consumed to keep the streams aligned, and the result is 0.
- `err` clears at the next CMD firing.

Reset values: all strobes 0, `fc` 0, `err` 0, `result_out` 0, `length_out` 0, `next_mode_out` = CMD, state IDLE.

Reset asserted mid-firing aborts the firing immediately. No further strobes are issued, and tokens already read are lost.

## Timing
Invoke is sampled at the end of cycle 0.
- CMD: `rd_cmd`/`rd_len` high in cycle 1; latch in cycle 2; `fc` in cycle 3.
- DATA, length L ≥ 1: `rd_data` high in cycles 1..L; `fc` in cycle L+2.
- OUT: `wr_result` in cycle 1; `fc` in cycle 2.
- `next_mode_out`, `length_out` and `err` are valid from the DONE cycle onward.
- `enable` follows populations combinationally.
- A new invoke is accepted the cycle after DONE at the earliest.

## Configuration
`STREAM_COMP_SAT_EN`:
- Defined: SUM saturates at 2^WIDTH−1.
- Undefined: SUM wraps modulo 2^WIDTH.
- MAX, MIN and XOR are unaffected either way.

## Structure
- Package `stream_comp_pkg`: mode constants, opcode constants, FSM state encoding, `log2` function.
- Sub-module `stream_comp_alu`: combinational single-step reduce. Inputs: accumulator, token, opcode. Outputs: next accumulator, illegal-opcode flag. Contains the `STREAM_COMP_SAT_EN` logic.

## Test plan
- Reset, then pop_cmd = pop_len = 1, mode CMD, invoke. Expect `rd_cmd`/`rd_len` in cycle 1, `fc` in cycle 3, `next_mode_out` = DATA, `length_out` = 5 for cmd = 0, len = 5.
- DATA with tokens 1, 2, 3, 4, 5 and SUM, then OUT with cap_result = 1. Expect 5 `rd_data` cycles, `fc` in cycle 7, `wr_result` with `result_out` = 15, `next_mode_out` = CMD.
- WIDTH = 10, SUM of 1000 + 100:
  - With `STREAM_COMP_SAT_EN`: result = 1023.
  - Without it: result = 76.
- MIN with len = 0: `next_mode_out` = OUT after CMD, result = 1023. Opcode 7 with len = 2: `err` = 1, 2 data tokens consumed, result = 0.
- Gating:
  - DATA with pop_data = 3 < length = 5: `enable` = 0, invoke ignored, no strobes.
  - OUT with cap_result = 0: `enable` = 0.
- `rst` low during DATA_RD after 2 of 5 reads: strobes drop immediately, state IDLE, `next_mode_out` = CMD, outputs 0.
